// File: rtl/stack_sequencer.sv
// Program-address sequencer with a hardware return-address stack (CALL/RET) and HOLD.
// Optional build macro PS_TRAP_EN: stack faults vector to TRAP_VEC instead of acting as a NOP.
module stack_sequencer #(
  parameter int            AW        = 4,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter logic [AW-1:0] TRAP_VEC  = '1
) (
  input  logic                         clk,
  input  logic                         sync_reset,
  input  logic                         hold,
  input  logic                         jmp,
  input  logic                         jmp_nz,
  input  logic                         dont_jmp,
  input  logic                         call,
  input  logic                         ret,
  input  logic [AW-1:0]                jmp_addr,
  output logic [AW-1:0]                pm_addr,
  output logic [AW-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         stack_err
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] stack_mem [DEPTH];
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] fault_addr;
  logic [SW-1:0] sp_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          push;
  logic          pop;
  logic          fault;

  assign pc_inc      = pc + AW'(1);
  assign sp_m1       = sp - SW'(1);
  // Index is only used when the push/pop is legal, so truncation never aliases.
  assign wr_idx      = sp[IW-1:0];
  assign rd_idx      = sp_m1[IW-1:0];
  assign stack_full  = (sp == SW'(DEPTH));
  assign stack_empty = (sp == '0);

`ifdef PS_TRAP_EN
  assign fault_addr = TRAP_VEC;
`else
  assign fault_addr = pc_inc;
`endif

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    pm_addr = pc_inc;
    if (sync_reset) begin
      pm_addr = RESET_VEC;
    end else if (hold) begin
      pm_addr = pc;
    end else if (ret) begin
      if (stack_empty) begin
        fault   = 1'b1;
        pm_addr = fault_addr;
      end else begin
        pop     = 1'b1;
        pm_addr = stack_mem[rd_idx];
      end
    end else if (call) begin
      if (stack_full) begin
        fault   = 1'b1;
        pm_addr = fault_addr;
      end else begin
        push    = 1'b1;
        pm_addr = jmp_addr;
      end
    end else if (jmp) begin
      pm_addr = jmp_addr;
    end else if (jmp_nz && !dont_jmp) begin
      pm_addr = jmp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc        <= RESET_VEC;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc <= pm_addr;
      if (push) sp <= sp + SW'(1);
      if (pop)  sp <= sp_m1;
      if (fault) stack_err <= 1'b1;
    end
  end

  // Stack contents are deliberately not reset; only sp defines validity.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomised and directed bench for stack_sequencer against a queue-based reference model.
module tb_stack_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       sync_reset = 1'b0, hold = 1'b0, jmp = 1'b0, jmp_nz = 1'b0;
  logic       dont_jmp = 1'b0, call = 1'b0, ret = 1'b0;
  logic [3:0] jmp_addr = 4'd0;
  logic [3:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_pc = 0;
  int         m_stack[$];
  bit         m_err = 0;
  logic [3:0] exp_pm, obs_pm;

  stack_sequencer #(.AW(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .sync_reset(sync_reset), .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz),
    .dont_jmp(dont_jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
    .pm_addr(pm_addr), .pc(pc), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // One cycle: drive, record pm_addr and the model's prediction, clock, advance the model.
  task automatic step(input bit r, h, j, jn, dz, c, rt, input logic [3:0] a);
    int  nxt;
    bit  flt;
    int  op; // 0 none, 1 push, 2 pop, 3 reset
    @(negedge clk);
    sync_reset = r; hold = h; jmp = j; jmp_nz = jn; dont_jmp = dz;
    call = c; ret = rt; jmp_addr = a;
    #1;
    obs_pm = pm_addr;
    nxt = (m_pc + 1) % 16;
    flt = 0; op = 0;
    if (r) begin nxt = 0; op = 3; end
    else if (h) nxt = m_pc;
    else if (rt) begin
      if (m_stack.size() == 0) flt = 1; else begin nxt = m_stack[$]; op = 2; end
    end else if (c) begin
      if (m_stack.size() == DEPTH) flt = 1; else begin nxt = a; op = 1; end
    end else if (j) nxt = a;
    else if (jn && !dz) nxt = a;
    if (flt) begin
`ifdef PS_TRAP_EN
      nxt = 15;
`else
      nxt = (m_pc + 1) % 16;
`endif
    end
    exp_pm = 4'(nxt);
    @(posedge clk);
    #1;
    if (op == 1) m_stack.push_back((m_pc + 1) % 16);
    if (op == 2) void'(m_stack.pop_back());
    if (op == 3) begin m_stack.delete(); m_err = 0; end
    if (flt) m_err = 1;
    m_pc = nxt;
    sync_reset = 0; hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 4'd0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 4'd0);
    checks += 5;
    if (obs_pm !== 4'd0) begin errors++; $display("FAIL reset_pm_addr got %0d expected 0", obs_pm); end
    if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d expected 0", pc); end
    if (sp !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d expected 0", sp); end
    if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags got empty=%0b full=%0b expected 1 0", stack_empty, stack_full);
    end
    if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", stack_err); end
  endtask

  task automatic test_idle();
    for (int i = 1; i <= 4; i++) begin
      idle();
      checks++;
      if (pc !== 4'(i) || sp !== 3'd0 || stack_empty !== 1'b1) begin
        errors++; $display("FAIL idle_count got pc=%0d sp=%0d expected pc=%0d sp=0", pc, sp, i);
      end
    end
  endtask

  task automatic test_call_ret();
    test_reset();
    repeat (3) idle();
    step(0, 0, 0, 0, 0, 1, 0, 4'd9);
    checks++;
    if (obs_pm !== 4'd9 || sp !== 3'd1) begin
      errors++; $display("FAIL call_target got pm=%0d sp=%0d expected pm=9 sp=1", obs_pm, sp);
    end
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checks++;
    if (obs_pm !== 4'd4 || sp !== 3'd0 || pc !== 4'd4) begin
      errors++; $display("FAIL ret_target got pm=%0d sp=%0d pc=%0d expected 4 0 4", obs_pm, sp, pc);
    end
  endtask

  task automatic test_jmp_nz_wrap();
    test_reset();
    step(0, 0, 0, 1, 1, 0, 0, 4'd6);
    checks++;
    if (obs_pm !== 4'd1) begin errors++; $display("FAIL jnz_not_taken got %0d expected 1", obs_pm); end
    step(0, 0, 0, 1, 0, 0, 0, 4'd6);
    checks++;
    if (obs_pm !== 4'd6) begin errors++; $display("FAIL jnz_taken got %0d expected 6", obs_pm); end
    step(0, 0, 1, 0, 0, 0, 0, 4'd15);
    idle();
    checks++;
    if (obs_pm !== 4'd0 || pc !== 4'd0) begin
      errors++; $display("FAIL pc_wrap got pm=%0d pc=%0d expected 0 0", obs_pm, pc);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] fexp;
    test_reset();
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 1, 0, 4'(i));
    checks++;
    if (sp !== 3'd4 || stack_full !== 1'b1) begin
      errors++; $display("FAIL fill_stack got sp=%0d full=%0b expected 4 1", sp, stack_full);
    end
    step(0, 0, 0, 0, 0, 1, 0, 4'd9);
`ifdef PS_TRAP_EN
    fexp = 4'd15;
`else
    fexp = 4'd5;
`endif
    checks++;
    if (obs_pm !== fexp || sp !== 3'd4 || stack_err !== 1'b1) begin
      errors++; $display("FAIL overflow got pm=%0d sp=%0d err=%0b expected %0d 4 1", obs_pm, sp, stack_err, fexp);
    end
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 0, 0, 0, 1, 4'd0);
      checks++;
      if (obs_pm !== 4'(i) || sp !== 3'(i - 1)) begin
        errors++; $display("FAIL unwind got pm=%0d sp=%0d expected %0d %0d", obs_pm, sp, i, i - 1);
      end
    end
    checks++;
    if (stack_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b expected 1", stack_err); end
  endtask

  task automatic test_underflow_priority();
    logic [3:0] hold_pc;
    test_reset();
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    checks++;
    if (stack_err !== 1'b1 || sp !== 3'd0 || obs_pm !== exp_pm) begin
      errors++; $display("FAIL underflow got err=%0b sp=%0d pm=%0d expected 1 0 %0d", stack_err, sp, obs_pm, exp_pm);
    end
    step(0, 0, 1, 0, 0, 1, 0, 4'd7);
    checks++;
    if (obs_pm !== 4'd7 || sp !== 3'd1) begin
      errors++; $display("FAIL call_over_jmp got pm=%0d sp=%0d expected 7 1", obs_pm, sp);
    end
    hold_pc = pc;
    step(0, 1, 0, 0, 0, 0, 1, 4'd0);
    checks++;
    if (pc !== hold_pc || obs_pm !== hold_pc || sp !== 3'd1) begin
      errors++; $display("FAIL hold_ret got pc=%0d sp=%0d expected %0d 1", pc, sp, hold_pc);
    end
  endtask

  task automatic test_reset_mid_call();
    test_reset();
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 0, 1, 0, 4'd3);
    step(0, 0, 0, 0, 0, 1, 0, 4'd8);
    checks++;
    if (sp !== 3'd2 || stack_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset got sp=%0d err=%0b expected 2 1", sp, stack_err);
    end
    step(1, 0, 0, 0, 0, 1, 0, 4'd12);
    checks++;
    if (obs_pm !== 4'd0 || pc !== 4'd0 || sp !== 3'd0 || stack_err !== 1'b0 || stack_empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid_call got pm=%0d pc=%0d sp=%0d err=%0b expected 0 0 0 0", obs_pm, pc, sp, stack_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      checks += 3;
      if (obs_pm !== exp_pm) begin
        errors++; $display("FAIL rand_pm_addr cycle %0d got %0d expected %0d", i, obs_pm, exp_pm);
      end
      if (pc !== 4'(m_pc) || sp !== 3'(m_stack.size())) begin
        errors++; $display("FAIL rand_state cycle %0d got pc=%0d sp=%0d expected %0d %0d", i, pc, sp, m_pc, m_stack.size());
      end
      if (stack_err !== m_err || stack_full !== (m_stack.size() == DEPTH) || stack_empty !== (m_stack.size() == 0)) begin
        errors++; $display("FAIL rand_flags cycle %0d got err=%0b full=%0b empty=%0b expected err=%0b size=%0d",
                           i, stack_err, stack_full, stack_empty, m_err, m_stack.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_call_ret();
    test_jmp_nz_wrap();
    test_overflow();
    test_underflow_priority();
    test_reset_mid_call();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
